// File: rtl/dual_muladd_seq.sv
// dual_muladd_seq: issues both lanes of a dual signed mul-add through one
// shared 3-stage pipeline at one pair per two cycles, reassembles the packed
// {dout0, dout1} result and buffers it in a credit-gated result FIFO.
module dual_muladd_seq #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [26:0] a0,
  input  logic [26:0] a1,
  input  logic [17:0] b0,
  input  logic [17:0] b1,
  input  logic [47:0] c0,
  input  logic [47:0] c1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] ap_return
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, LANE1} state_t;

  state_t      state_q, state_d;

  // Lane-1 operands parked while lane 0 enters the pipeline
  logic [26:0] hold_a_q, hold_a_d;
  logic [17:0] hold_b_q, hold_b_d;
  logic [47:0] hold_c_q, hold_c_d;

  // Shared pipeline, one lane tag per stage
  logic        s1_vld_q, s1_vld_d, s1_tag_q, s1_tag_d;
  logic [26:0] s1_a_q, s1_a_d;
  logic [17:0] s1_b_q, s1_b_d;
  logic [47:0] s1_c_q, s1_c_d;
  logic        s2_vld_q, s2_vld_d, s2_tag_q, s2_tag_d;
  logic [44:0] s2_m_q, s2_m_d;
  logic [47:0] s2_c_q, s2_c_d;
  logic        s3_vld_q, s3_vld_d, s3_tag_q, s3_tag_d;
  logic [47:0] s3_p_q, s3_p_d;

  // Collection and result FIFO
  logic [47:0] lane0_q, lane0_d;
  logic [95:0] mem_q [DEPTH];
  logic [95:0] mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d;

  logic        credit_ok, accept, push, pop;
  logic [44:0] a_ext, b_ext;

  // Handshake qualifiers and visible outputs
  always_comb begin
    credit_ok = (32'(inflight_q) + 32'(count_q)) < DEPTH;
    in_ready  = ~ap_rst & ap_ce & (state_q == IDLE) & credit_ok;
    accept    = in_valid & in_ready;
    out_valid = (count_q != '0);
    ap_return = out_valid ? mem_q[rd_ptr_q] : '0;
    push      = s3_vld_q & s3_tag_q;
    pop       = out_ready & out_valid;
  end

  // Issue FSM: lane 0 on accept, lane 1 from the hold register next cycle
  always_comb begin
    state_d  = state_q;
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    hold_c_d = hold_c_q;
    s1_vld_d = 1'b0;
    s1_tag_d = 1'b0;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_c_d   = s1_c_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          s1_vld_d = 1'b1;
          s1_tag_d = 1'b0;
          s1_a_d   = a0;
          s1_b_d   = b0;
          s1_c_d   = c0;
          hold_a_d = a1;
          hold_b_d = b1;
          hold_c_d = c1;
          state_d  = LANE1;
        end
      end
      LANE1: begin
        s1_vld_d = 1'b1;
        s1_tag_d = 1'b1;
        s1_a_d   = hold_a_q;
        s1_b_d   = hold_b_q;
        s1_c_d   = hold_c_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiply in S2, sign-extended add modulo 2^48 in S3
  always_comb begin
    // Equal-width sign-extended operands give the exact 45-bit signed product
    a_ext    = {{18{s1_a_q[26]}}, s1_a_q};
    b_ext    = {{27{s1_b_q[17]}}, s1_b_q};
    s2_vld_d = s1_vld_q;
    s2_tag_d = s1_tag_q;
    s2_m_d   = a_ext * b_ext;
    s2_c_d   = s1_c_q;
    s3_vld_d = s2_vld_q;
    s3_tag_d = s2_tag_q;
    s3_p_d   = {{3{s2_m_q[44]}}, s2_m_q} + s2_c_q;
  end

  // Pair reassembly, FIFO pointers/occupancy and outstanding-pair credits
  always_comb begin
    lane0_d  = lane0_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    inflight_d = inflight_q;
    if (s3_vld_q && !s3_tag_q) begin
      lane0_d = s3_p_q;
    end
    if (push) begin
      mem_d[wr_ptr_q] = {lane0_q, s3_p_q};
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    if (accept && !push) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!accept && push) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  // State registers: synchronous reset, everything frozen while ap_ce is low
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= IDLE;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      hold_c_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_tag_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s2_vld_q   <= 1'b0;
      s2_tag_q   <= 1'b0;
      s2_m_q     <= '0;
      s2_c_q     <= '0;
      s3_vld_q   <= 1'b0;
      s3_tag_q   <= 1'b0;
      s3_p_q     <= '0;
      lane0_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else if (ap_ce) begin
      state_q    <= state_d;
      hold_a_q   <= hold_a_d;
      hold_b_q   <= hold_b_d;
      hold_c_q   <= hold_c_d;
      s1_vld_q   <= s1_vld_d;
      s1_tag_q   <= s1_tag_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
      s2_vld_q   <= s2_vld_d;
      s2_tag_q   <= s2_tag_d;
      s2_m_q     <= s2_m_d;
      s2_c_q     <= s2_c_d;
      s3_vld_q   <= s3_vld_d;
      s3_tag_q   <= s3_tag_d;
      s3_p_q     <= s3_p_d;
      lane0_q    <= lane0_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_dual_muladd_seq.sv
// tb_dual_muladd_seq: scoreboard bench for dual_muladd_seq.
module tb_dual_muladd_seq;

  localparam int unsigned DEPTH = 4;

  logic        ap_clk = 1'b0;
  logic        ap_rst, ap_ce, in_valid, in_ready, out_valid, out_ready;
  logic [26:0] a0, a1;
  logic [17:0] b0, b1;
  logic [47:0] c0, c1;
  logic [95:0] ap_return;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [95:0] sb [$];
  int          pop_cycles [$];

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  dual_muladd_seq #(.DEPTH(DEPTH)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_ce     (ap_ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a0        (a0),
    .a1        (a1),
    .b0        (b0),
    .b1        (b1),
    .c0        (c0),
    .c1        (c1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ap_return (ap_return)
  );

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference lane result computed in 64-bit integer arithmetic
  function automatic logic [47:0] lane_ref(input logic [26:0] a, input logic [17:0] b,
                                           input logic [47:0] c);
    longint sa, sbv, sc, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    sc  = longint'($signed(c));
    r   = sa * sbv + sc;
    return r[47:0];
  endfunction

  // Scoreboard: push on accept, pop and compare on consume, flush on reset
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      sb.delete();
    end else if (ap_ce) begin
      if (in_valid && in_ready)
        sb.push_back({lane_ref(a0, b0, c0), lane_ref(a1, b1, c1)});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 96'(out_valid), 96'd0);
        end else begin
          check_eq("sb_data", ap_return, sb.pop_front());
          pop_cycles.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ap_clk);
    #2;
  endtask

  task automatic set_req(input logic [26:0] ia0, input logic [17:0] ib0, input logic [47:0] ic0,
                         input logic [26:0] ia1, input logic [17:0] ib1, input logic [47:0] ic1);
    a0 = ia0; b0 = ib0; c0 = ic0;
    a1 = ia1; b1 = ib1; c1 = ic1;
  endtask

  task automatic rand_req();
    logic [63:0] r0, r1;
    r0 = {$urandom(), $urandom()};
    r1 = {$urandom(), $urandom()};
    a0 = 27'($urandom()); a1 = 27'($urandom());
    b0 = 18'($urandom()); b1 = 18'($urandom());
    c0 = r0[47:0];        c1 = r1[47:0];
  endtask

  // Holds in_valid until accepted or the budget runs out; called at posedge+2
  task automatic attempt(input int budget, output bit ok, output int acc_cyc);
    ok = 1'b0;
    acc_cyc = -1;
    in_valid = 1'b1;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge ap_clk);
      if (in_ready && ap_ce && !ap_rst) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge ap_clk);
      #2;
    end
    in_valid = 1'b0;
  endtask

  // Latency in edges from the accept edge to the edge that raised out_valid
  task automatic wait_out(input string tag, input int acc_cyc, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge ap_clk);
      if (out_valid) begin
        lat = cyc - acc_cyc - 1;
        break;
      end
    end
    check_eq(tag, 96'(lat), 96'(exp_lat));
  endtask

  initial begin
    bit ok;
    int t, ta, tb2, prev, n_acc, bad_gap, stale;
    logic [95:0] exp_pair;

    ap_rst = 1'b1; ap_ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_req('0, '0, '0, '0, '0, '0);
    tick(); tick();
    @(negedge ap_clk);
    check_eq("rst_out_valid", 96'(out_valid), 96'd0);
    check_eq("rst_ap_return", ap_return, 96'd0);
    check_eq("rst_in_ready", 96'(in_ready), 96'd0);
    tick();
    ap_rst = 1'b0;

    // Basic pair
    set_req(27'd3, -18'sd2, 48'd10, -27'sd5, 18'd7, 48'd0);
    attempt(20, ok, t);
    check_eq("basic_accept", 96'(ok), 96'd1);
    @(negedge ap_clk);
    check_eq("basic_ready_lane1", 96'(in_ready), 96'd0);
    @(negedge ap_clk);
    check_eq("basic_ready_idle", 96'(in_ready), 96'd1);
    wait_out("basic_latency", t, 4);
    check_eq("basic_value", ap_return, {48'h000000000004, 48'hFFFFFFFFFFDD});

    // Wrap at 2^48 and extreme signed operands
    tick();
    set_req(27'd1, 18'd1, 48'h7FFFFFFFFFFF, 27'h7FFFFFF, 18'h20000, 48'd0);
    attempt(20, ok, t);
    wait_out("wrap_latency", t, 4);
    check_eq("wrap_value", ap_return, {48'h800000000000, 48'h000000020000});

    // Backpressure: only DEPTH pairs outstanding
    tick(); tick();
    out_ready = 1'b0;
    n_acc = 0;
    for (int r = 0; r < 4; r++) begin
      rand_req();
      attempt(20, ok, t);
      n_acc += int'(ok);
    end
    rand_req();
    attempt(16, ok, t);
    n_acc += int'(ok);
    check_eq("bp_accepted", 96'(n_acc), 96'(DEPTH));
    pop_cycles.delete();
    out_ready = 1'b1;
    attempt(20, ok, t);
    check_eq("bp_resume5", 96'(ok), 96'd1);
    rand_req();
    attempt(20, ok, t);
    check_eq("bp_resume6", 96'(ok), 96'd1);
    repeat (14) tick();
    check_eq("bp_drain_count", 96'(pop_cycles.size()), 96'd6);
    if (pop_cycles.size() >= 4)
      check_eq("bp_drain_burst", 96'(pop_cycles[3] - pop_cycles[0]), 96'd3);

    // Streaming: one accept every two cycles
    pop_cycles.delete();
    prev = -1; bad_gap = 0; n_acc = 0;
    for (int r = 0; r < 100; r++) begin
      rand_req();
      attempt(20, ok, t);
      if (ok) begin
        n_acc++;
        if (prev >= 0 && t - prev != 2) bad_gap++;
        prev = t;
      end
    end
    check_eq("stream_accepted", 96'(n_acc), 96'd100);
    check_eq("stream_gaps", 96'(bad_gap), 96'd0);
    repeat (10) tick();
    check_eq("stream_pops", 96'(pop_cycles.size()), 96'd100);
    check_eq("stream_sb_empty", 96'(sb.size()), 96'd0);

    // ap_ce gap of 3 cycles in LANE1 with two pairs in flight
    rand_req();
    attempt(20, ok, ta);
    rand_req();
    attempt(20, ok, tb2);
    ap_ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      check_eq("ce_gap_in_ready", 96'(in_ready), 96'd0);
      check_eq("ce_gap_out_valid", 96'(out_valid), 96'd0);
    end
    tick();
    ap_ce = 1'b1;
    wait_out("ce_lat_a", ta, 7);
    wait_out("ce_lat_b", tb2, 7);

    // ap_ce low holds a buffered pair even with out_ready high
    tick();
    out_ready = 1'b0;
    rand_req();
    exp_pair = {lane_ref(a0, b0, c0), lane_ref(a1, b1, c1)};
    attempt(20, ok, t);
    wait_out("hold_latency", t, 4);
    tick();
    ap_ce = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      check_eq("ce_hold_valid", 96'(out_valid), 96'd1);
      check_eq("ce_hold_data", ap_return, exp_pair);
    end
    tick();
    ap_ce = 1'b1;
    repeat (3) tick();
    check_eq("ce_hold_drained", 96'(sb.size()), 96'd0);

    // Reset with one pair buffered and two in flight
    out_ready = 1'b0;
    rand_req();
    attempt(20, ok, t);
    wait_out("rst_buf_latency", t, 4);
    tick();
    rand_req();
    attempt(20, ok, t);
    rand_req();
    attempt(20, ok, t);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check_eq("pre_rst_buffered", 96'(out_valid), 96'd1);
    check_eq("rst_hi_in_ready", 96'(in_ready), 96'd0);
    tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check_eq("post_rst_out_valid", 96'(out_valid), 96'd0);
    check_eq("post_rst_ap_return", ap_return, 96'd0);
    tick();
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ap_clk);
      if (out_valid) stale++;
    end
    check_eq("post_rst_no_stale", 96'(stale), 96'd0);
    tick();
    rand_req();
    attempt(20, ok, t);
    check_eq("post_rst_accept", 96'(ok), 96'd1);
    wait_out("post_rst_latency", t, 4);

    repeat (8) tick();
    check_eq("final_sb_empty", 96'(sb.size()), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
